// File: rtl/program_counter_ras.sv
// Fetch-stage program counter with stall, jump, and a circular return-address stack.
// Call/return redirect fetch directly from the stack, and ras_error latches any over/underflow.
module program_counter_ras #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      STEP         = 4,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             enable_overwrite,
    input  logic [WIDTH-1:0] overwrite_value,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc_value,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_error
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             error_q, error_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic             rasWe;
    logic [PTR_W-1:0] rasWaddr;
    logic [WIDTH-1:0] rasWdata;
    logic [WIDTH-1:0] nextSeq;
    logic             isEmpty;
    logic             isFull;

    assign nextSeq = pc_q + WIDTH'(STEP);
    assign isEmpty = (count_q == '0);
    assign isFull  = (count_q == CNT_FULL);

    // Push onto a full stack advances top past the oldest entry, overwriting it.
    always_comb begin
        pc_d     = pc_q;
        top_d    = top_q;
        count_d  = count_q;
        error_d  = error_q;
        rasWe    = 1'b0;
        rasWaddr = top_q;
        rasWdata = nextSeq;
        if (stall) begin
            pc_d = pc_q;
        end else if (call && ret && !isEmpty) begin
            pc_d     = overwrite_value;
            rasWe    = 1'b1;
            rasWaddr = top_q;
        end else if (ret && !call) begin
            if (!isEmpty) begin
                pc_d    = ras_q[top_q];
                top_d   = top_q - 1'b1;
                count_d = count_q - 1'b1;
            end else begin
                pc_d    = nextSeq;
                error_d = 1'b1;
            end
        end else if (call) begin
            pc_d     = overwrite_value;
            rasWe    = 1'b1;
            rasWaddr = top_q + 1'b1;
            top_d    = top_q + 1'b1;
            if (isFull) begin
                error_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (enable_overwrite) begin
            pc_d = overwrite_value;
        end else begin
            pc_d = nextSeq;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            top_q   <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            top_q   <= top_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    // Entry contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clock) begin
        if (rasWe) begin
            ras_q[rasWaddr] <= rasWdata;
        end
    end

    assign pc_value  = pc_q;
    assign ras_empty = isEmpty;
    assign ras_full  = isFull;
    assign ras_error = error_q;

endmodule

// File: tb/tb_program_counter_ras.sv
// Directed bench for program_counter_ras: sequencing, jump, stall, call/return nesting,
// overflow, underflow, tail call, wrap-around and stall priority.
module tb_program_counter_ras;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        enable_overwrite = 1'b0;
    logic [31:0] overwrite_value = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] pc_value;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_error;

    int vectors = 0;
    int misses  = 0;

    program_counter_ras #(
        .WIDTH(32), .RESET_VECTOR(32'h0), .STEP(4), .RAS_DEPTH(4)
    ) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .enable_overwrite(enable_overwrite), .overwrite_value(overwrite_value),
        .call(call), .ret(ret), .pc_value(pc_value),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_error(ras_error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        stall = 0; enable_overwrite = 0; call = 0; ret = 0; overwrite_value = '0;
    endtask

    task automatic doReset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        #3;
        reset = 1;
        #1;
        vectors++;
        if (pc_value !== 32'h0 || ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_error !== 1'b0) begin
            misses++;
            $display("[TB] FAIL reset_async pc=%h empty=%b full=%b err=%b required pc=0 empty=1 full=0 err=0",
                     pc_value, ras_empty, ras_full, ras_error);
        end
        tick();
        reset = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++;
            if (pc_value !== 32'(4 * i) || ras_empty !== 1'b1) begin
                misses++;
                $display("[TB] FAIL seq%0d pc=%h empty=%b required pc=%h empty=1",
                         i, pc_value, ras_empty, 32'(4 * i));
            end
        end
    endtask

    task automatic test_jump_stall();
        doReset();
        tick(); tick();
        vectors++;
        if (pc_value !== 32'h8) begin
            misses++; $display("[TB] FAIL jump_start pc=%h required 00000008", pc_value);
        end
        enable_overwrite = 1; overwrite_value = 32'h42;
        tick();
        idle();
        vectors++;
        if (pc_value !== 32'h42) begin
            misses++; $display("[TB] FAIL jump pc=%h required 00000042", pc_value);
        end
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (pc_value !== 32'h42) begin
                misses++; $display("[TB] FAIL stall%0d pc=%h required 00000042", i, pc_value);
            end
        end
        stall = 0;
        tick();
        vectors++;
        if (pc_value !== 32'h46) begin
            misses++; $display("[TB] FAIL stall_release pc=%h required 00000046", pc_value);
        end
    endtask

    task automatic test_call_return();
        doReset();
        enable_overwrite = 1; overwrite_value = 32'h10;
        tick();
        idle();
        call = 1; overwrite_value = 32'h100;
        tick();
        vectors++;
        if (pc_value !== 32'h100 || ras_empty !== 1'b0) begin
            misses++; $display("[TB] FAIL call1 pc=%h empty=%b required pc=00000100 empty=0", pc_value, ras_empty);
        end
        overwrite_value = 32'h200;
        tick();
        vectors++;
        if (pc_value !== 32'h200) begin
            misses++; $display("[TB] FAIL call2 pc=%h required 00000200", pc_value);
        end
        idle(); ret = 1;
        tick();
        vectors++;
        if (pc_value !== 32'h104) begin
            misses++; $display("[TB] FAIL ret1 pc=%h required 00000104", pc_value);
        end
        tick();
        idle();
        vectors++;
        if (pc_value !== 32'h14 || ras_empty !== 1'b1 || ras_error !== 1'b0) begin
            misses++; $display("[TB] FAIL ret2 pc=%h empty=%b err=%b required pc=00000014 empty=1 err=0",
                               pc_value, ras_empty, ras_error);
        end
    endtask

    task automatic test_overflow();
        doReset();
        call = 1; overwrite_value = 32'h1000;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 4) begin
                vectors++;
                if (ras_full !== 1'b1 || ras_error !== 1'b0) begin
                    misses++; $display("[TB] FAIL call4_full full=%b err=%b required full=1 err=0", ras_full, ras_error);
                end
            end
        end
        vectors++;
        if (pc_value !== 32'h1000 || ras_full !== 1'b1 || ras_error !== 1'b1) begin
            misses++; $display("[TB] FAIL overflow pc=%h full=%b err=%b required pc=00001000 full=1 err=1",
                               pc_value, ras_full, ras_error);
        end
        idle(); ret = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (pc_value !== 32'h1004) begin
                misses++; $display("[TB] FAIL overflow_ret%0d pc=%h required 00001004", i, pc_value);
            end
        end
        idle();
        vectors++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
            misses++; $display("[TB] FAIL overflow_drain empty=%b full=%b required empty=1 full=0", ras_empty, ras_full);
        end
    endtask

    task automatic test_underflow_tail();
        doReset();
        enable_overwrite = 1; overwrite_value = 32'h20;
        tick();
        idle();
        ret = 1; enable_overwrite = 1; overwrite_value = 32'hDEAD0;
        tick();
        idle();
        vectors++;
        if (pc_value !== 32'h24 || ras_error !== 1'b1 || ras_empty !== 1'b1) begin
            misses++; $display("[TB] FAIL underflow pc=%h err=%b empty=%b required pc=00000024 err=1 empty=1",
                               pc_value, ras_error, ras_empty);
        end
        tick();
        vectors++;
        if (pc_value !== 32'h28 || ras_error !== 1'b1) begin
            misses++; $display("[TB] FAIL error_sticky pc=%h err=%b required pc=00000028 err=1", pc_value, ras_error);
        end
        doReset();
        vectors++;
        if (ras_error !== 1'b0) begin
            misses++; $display("[TB] FAIL error_clear err=%b required 0", ras_error);
        end
        call = 1; overwrite_value = 32'h80;
        tick();
        call = 1; ret = 1; overwrite_value = 32'h300;
        tick();
        idle();
        vectors++;
        if (pc_value !== 32'h300 || ras_empty !== 1'b0 || ras_full !== 1'b0 || ras_error !== 1'b0) begin
            misses++; $display("[TB] FAIL tail_call pc=%h empty=%b full=%b err=%b required pc=00000300 empty=0 full=0 err=0",
                               pc_value, ras_empty, ras_full, ras_error);
        end
        ret = 1;
        tick();
        idle();
        vectors++;
        if (pc_value !== 32'h84 || ras_empty !== 1'b1 || ras_error !== 1'b0) begin
            misses++; $display("[TB] FAIL tail_ret pc=%h empty=%b err=%b required pc=00000084 empty=1 err=0",
                               pc_value, ras_empty, ras_error);
        end
        call = 1; ret = 1; overwrite_value = 32'h600;
        tick();
        idle();
        vectors++;
        if (pc_value !== 32'h600 || ras_empty !== 1'b0) begin
            misses++; $display("[TB] FAIL tail_empty pc=%h empty=%b required pc=00000600 empty=0", pc_value, ras_empty);
        end
        ret = 1;
        tick();
        idle();
        vectors++;
        if (pc_value !== 32'h88 || ras_empty !== 1'b1 || ras_error !== 1'b0) begin
            misses++; $display("[TB] FAIL tail_empty_ret pc=%h empty=%b err=%b required pc=00000088 empty=1 err=0",
                               pc_value, ras_empty, ras_error);
        end
    endtask

    task automatic test_wrap_stall_priority();
        doReset();
        enable_overwrite = 1; overwrite_value = 32'hFFFFFFFC;
        tick();
        idle();
        vectors++;
        if (pc_value !== 32'hFFFFFFFC) begin
            misses++; $display("[TB] FAIL wrap_jump pc=%h required fffffffc", pc_value);
        end
        tick();
        vectors++;
        if (pc_value !== 32'h0) begin
            misses++; $display("[TB] FAIL wrap pc=%h required 00000000", pc_value);
        end
        call = 1; overwrite_value = 32'h500;
        tick();
        stall = 1; call = 1; overwrite_value = 32'h900;
        tick();
        vectors++;
        if (pc_value !== 32'h500 || ras_empty !== 1'b0 || ras_full !== 1'b0 || ras_error !== 1'b0) begin
            misses++; $display("[TB] FAIL stall_call pc=%h empty=%b full=%b err=%b required pc=00000500 empty=0 full=0 err=0",
                               pc_value, ras_empty, ras_full, ras_error);
        end
        call = 0; ret = 1;
        tick();
        vectors++;
        if (pc_value !== 32'h500 || ras_empty !== 1'b0) begin
            misses++; $display("[TB] FAIL stall_ret pc=%h empty=%b required pc=00000500 empty=0", pc_value, ras_empty);
        end
        stall = 0;
        tick();
        idle();
        vectors++;
        if (pc_value !== 32'h4 || ras_empty !== 1'b1 || ras_error !== 1'b0) begin
            misses++; $display("[TB] FAIL post_stall_ret pc=%h empty=%b err=%b required pc=00000004 empty=1 err=0",
                               pc_value, ras_empty, ras_error);
        end
    endtask

    initial begin
        test_reset();
        test_jump_stall();
        test_call_return();
        test_overflow();
        test_underflow_tail();
        test_wrap_stall_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
